// File: rtl/dec_arb_pkg.sv
// rtl/dec_arb_pkg.sv - shared types, defaults and helpers for the decoder round-robin arbiter
//
// Contents:
//   DEC_ARB_N_DEFAULT        default requester count
//   DEC_ARB_MAX_HOLD_DEFAULT default grant-hold limit (ARB_TIMEOUT_EN builds)
//   arb_state_e              arbiter FSM state
//   mod_inc()                modulo-n increment used for the priority pointer
package dec_arb_pkg;

    localparam int DEC_ARB_N_DEFAULT        = 4;
    localparam int DEC_ARB_MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/dec_n_en.sv
// rtl/dec_n_en.sv - N-output binary decoder with enable
//
// Ports:
//   E  in   1          enable; Y is all zero when low
//   A  in   $clog2(N)  address to decode
//   Y  out  N          one-hot of A when E=1
module dec_n_en #(
    parameter int N = 4
) (
    input  logic                 E,
    input  logic [$clog2(N)-1:0] A,
    output logic [N-1:0]         Y
);

    always_comb begin
        Y = '0;
        if (E) begin
            Y = N'(1) << A;
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// rtl/dec_rr_arbiter.sv - round-robin arbiter driving a shared enabled decoder
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   req        in   N      level requests, held until done with the resource
//   gnt        out  N      one-hot grant (decoder output), zero when idle
//   gnt_idx    out  IDX_W  index of granted agent (decoder address)
//   gnt_valid  out  1      grant active (decoder enable)
//   preempt    out  1      one-cycle pulse on forced release
//
// Optional: define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles;
// otherwise a grant is held while its request stays high and preempt is 0.
module dec_rr_arbiter
    import dec_arb_pkg::*;
#(
    parameter int N        = DEC_ARB_N_DEFAULT,
    parameter int MAX_HOLD = DEC_ARB_MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 preempt
);

    localparam int IDX_W = $clog2(N);

    if (N < 2 || (N & (N - 1)) != 0 || MAX_HOLD < 2) begin : g_bad_params
        $error("dec_rr_arbiter: N must be a power of two >= 2 and MAX_HOLD >= 2");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] pick, cand, idx_next;
    logic             pick_found;

    // First requester at or after ptr; the IDX_W-bit add wraps modulo N
    // because N is a power of two.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign idx_next = IDX_W'(mod_inc(32'(idx_q), N));

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              preempt_q, preempt_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d   = pick;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    ptr_d   = idx_next;
                    state_d = IDLE;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    // Forced release: the holder drops to lowest priority.
                    ptr_d     = idx_next;
                    state_d   = IDLE;
                    preempt_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    ptr_d   = idx_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    dec_n_en #(
        .N(N)
    ) u_dec (
        .E(gnt_valid),
        .A(idx_q),
        .Y(gnt)
    );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb/tb_dec_rr_arbiter.sv - scoreboard bench for dec_rr_arbiter
module tb_dec_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         preempt;

    always #5 clk = ~clk;

    dec_rr_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt(preempt)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         valid;
        logic         pre;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural reference of the arbiter
    bit m_grant;
    int m_ptr;
    int m_idx;
    int m_hold;
    bit m_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0;
        m_ptr   = 0;
        m_idx   = 0;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        bit found;
        int j;
        m_pre = 1'b0;
        found = 1'b0;
        if (!m_grant) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && r[j]) begin
                    found   = 1'b1;
                    m_idx   = j;
                    m_grant = 1'b1;
                    m_hold  = 0;
                end
            end
        end else if (!r[m_idx]) begin
            m_grant = 1'b0;
            m_ptr   = (m_idx + 1) % N;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_hold == MAX_HOLD - 1) begin
                m_grant = 1'b0;
                m_ptr   = (m_idx + 1) % N;
                m_pre   = 1'b1;
            end else begin
                m_hold++;
            end
`else
            if (m_hold < MAX_HOLD - 1) m_hold++;
`endif
        end
    endtask

    // Drive one request pattern across one rising edge and score the outputs.
    task automatic cyc(input logic [N-1:0] r, input string tag);
        exp_t e;
        exp_t o;
        req = r;
        model_edge(r);
        e = '0;
        if (m_grant) e.gnt[m_idx] = 1'b1;
        e.idx   = 2'(m_idx);
        e.valid = m_grant;
        e.pre   = m_pre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check({tag, ".gnt"},       32'(gnt),       32'(o.gnt));
        check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(o.idx));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(o.valid));
        check({tag, ".preempt"},   32'(preempt),   32'(o.pre));
    endtask

    initial begin
        logic [N-1:0] mask;
        int n_agent0;
        int n_pre;

        // Reset with all requests high, before any clock edge
        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        #2;
        check("reset.gnt",       32'(gnt),       32'h0);
        check("reset.gnt_idx",   32'(gnt_idx),   32'h0);
        check("reset.gnt_valid", 32'(gnt_valid), 32'h0);
        check("reset.preempt",   32'(preempt),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First grant one cycle after reset release
        cyc(4'b1111, "rel");
        check("rel.first_gnt", 32'(gnt), 32'b0001);
        cyc(4'b1111, "rel_hold");
        cyc(4'b1110, "rel_drop");
        check("rel.gap", 32'(gnt_valid), 32'h0);

        // Fairness: strict rotation 1,2,3,0 with an idle cycle between grants
        for (int g = 1; g <= 4; g++) begin
            cyc(4'b1111, "fair_grant");
            check("fair.order", 32'(gnt_idx), 32'(g % N));
            cyc(4'b1111, "fair_hold");
            mask = 4'b1111;
            mask[g % N] = 1'b0;
            cyc(mask, "fair_drop");
            check("fair.gap", 32'(gnt_valid), 32'h0);
        end

        // Single requester, three granted cycles then release (ptr -> 3)
        for (int c = 0; c < 3; c++) begin
            cyc(4'b0100, "single");
            check("single.gnt", 32'(gnt), 32'b0100);
        end
        cyc(4'b0000, "single_rel");

        // Wrap: ptr=3 picks agent 3 before agent 0
        cyc(4'b1001, "wrap_first");
        check("wrap.first", 32'(gnt_idx), 32'h3);
        cyc(4'b0001, "wrap_drop");
        cyc(4'b0001, "wrap_next");
        check("wrap.next", 32'(gnt_idx), 32'h0);
        cyc(4'b0000, "wrap_rel");

        // Non-granted request changes do not disturb an active grant
        cyc(4'b0010, "mask_grant");
        cyc(4'b1011, "mask_a");
        cyc(4'b0111, "mask_b");
        cyc(4'b1110, "mask_c");
        check("mask.gnt", 32'(gnt), 32'b0010);

        // Asynchronous reset between edges while agent 1 is granted
        #2;
        rst = 1'b1;
        #1;
        check("arst.gnt",       32'(gnt),       32'h0);
        check("arst.gnt_valid", 32'(gnt_valid), 32'h0);
        check("arst.gnt_idx",   32'(gnt_idx),   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ptr back at 0: agent 0 wins over agent 1; then hold both requests
        cyc(4'b0011, "ptr0");
        check("ptr0.idx", 32'(gnt_idx), 32'h0);
        n_agent0 = (gnt == 4'b0001) ? 1 : 0;
        n_pre    = 0;
        for (int c = 0; c < 11; c++) begin
            cyc(4'b0011, "hold");
            if (gnt == 4'b0001) n_agent0++;
            if (preempt) n_pre++;
        end
`ifdef ARB_TIMEOUT_EN
        check("hold.agent0_cycles", 32'(n_agent0), 32'(MAX_HOLD));
        check("hold.preempt_pulses", 32'(n_pre), 32'h1);
`else
        check("hold.agent0_cycles", 32'(n_agent0), 32'd12);
        check("hold.preempt_pulses", 32'(n_pre), 32'h0);
`endif
        cyc(4'b0000, "drain");
        cyc(4'b0000, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
